// File: rtl/bcd_frame_sched_pkg.sv
// Shared types and constants for the BCD frame scheduler: FSM states, requester IDs and ASCII bytes.
package bcd_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV,
        ST_HDR,
        ST_DIG,
        ST_CR,
        ST_LF
    } state_t;

    typedef enum logic {
        SRC_MEAS = 1'b0,
        SRC_CAL  = 1'b1
    } src_t;

    localparam logic [7:0] ZERO  = 8'h30;
    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;

    // Number of BCD nibbles needed to hold any w-bit binary value.
    function automatic int digitsFor(input int w);
        return (w + (w - 4) / 3 + 4) / 4;
    endfunction

endpackage

// File: rtl/bcd_frame_sched_if.sv
// Request/ack handshakes, the byte stream towards the radio and the busy flag of the BCD frame scheduler.
interface bcd_frame_sched_if #(
    parameter int W = 16
);

    logic         meas_req;
    logic [W-1:0] meas_val;
    logic         meas_ack;
    logic         cal_req;
    logic [W-1:0] cal_val;
    logic         cal_ack;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         busy;

    // The scheduler side: serves the requesters and drives the byte stream.
    modport master (
        input  meas_req, meas_val, cal_req, cal_val, tx_ready,
        output meas_ack, cal_ack, tx_data, tx_valid, busy
    );

    // The environment side: requesters and the radio sender.
    modport slave (
        output meas_req, meas_val, cal_req, cal_val, tx_ready,
        input  meas_ack, cal_ack, tx_data, tx_valid, busy
    );

endinterface

// File: rtl/bcd_frame_sched_bin2bcd.sv
// Combinational binary-to-BCD converter (shift-and-add-3), W-bit input, DIGITS nibbles out.
module bin2bcd #(
    parameter int W      = 16,
    parameter int DIGITS = (W + (W - 4) / 3 + 4) / 4
) (
    input  logic [W-1:0]          i_bin,
    output logic [4*DIGITS-1:0]   o_bcd
);

    logic [4*DIGITS-1:0] w_acc;

    // Before each shift, any nibble of 5 or more is bumped by 3 so it carries correctly into the next digit.
    always_comb begin
        w_acc = '0;
        for (int i = W - 1; i >= 0; i--) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (w_acc[4*d +: 4] > 4'd4) begin
                    w_acc[4*d +: 4] = w_acc[4*d +: 4] + 4'd3;
                end
            end
            w_acc = {w_acc[4*DIGITS-2:0], i_bin[i]};
        end
    end

    assign o_bcd = w_acc;

endmodule

// File: rtl/bcd_frame_sched.sv
// Round-robin shares the bin2bcd converter between measurement and calibration and streams ASCII frames.
// Optional feature: define LZ_SUPPRESS_EN to send leading zero digits as spaces.
module bcd_frame_sched
    import bcd_frame_pkg::*;
#(
    parameter int         W        = 16,
    parameter logic [7:0] HDR_MEAS = 8'h4D,
    parameter logic [7:0] HDR_CAL  = 8'h43
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_frame_sched_if.master    bus
);

    localparam int DIGITS = digitsFor(W);
    localparam int IDXW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t              r_state;
    state_t              w_nextState;
    src_t                r_lastGrant;
    src_t                r_src;
    logic [W-1:0]        r_opReg;
    logic [4*DIGITS-1:0] r_bcdReg;
    logic [IDXW-1:0]     r_digIdx;
    logic                r_seenNz;
    logic                r_measAck;
    logic                r_calAck;
    logic                r_txValid;
    logic [7:0]          r_txData;

    logic                w_grant;
    src_t                w_grantSrc;
    logic                w_fire;
    logic [IDXW-1:0]     w_nextIdx;
    logic                w_nextSeen;
    logic [3:0]          w_curDigit;
    logic [3:0]          w_nextDigit;
    logic [7:0]          w_nextData;
    logic [4*DIGITS-1:0] w_conv;

    bin2bcd #(
        .W      (W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .i_bin (r_opReg),
        .o_bcd (w_conv)
    );

    assign w_fire     = r_txValid & bus.tx_ready;
    assign w_curDigit = r_bcdReg[r_digIdx*4 +: 4];

    // On a tie the requester that did not win last time is served.
    always_comb begin
        w_nextState = r_state;
        w_grant     = 1'b0;
        w_grantSrc  = SRC_MEAS;
        w_nextIdx   = r_digIdx;
        w_nextSeen  = r_seenNz;
        case (r_state)
            ST_IDLE: begin
                if (bus.meas_req && bus.cal_req) begin
                    w_grant    = 1'b1;
                    w_grantSrc = (r_lastGrant == SRC_CAL) ? SRC_MEAS : SRC_CAL;
                end else if (bus.meas_req) begin
                    w_grant    = 1'b1;
                    w_grantSrc = SRC_MEAS;
                end else if (bus.cal_req) begin
                    w_grant    = 1'b1;
                    w_grantSrc = SRC_CAL;
                end
                if (w_grant) begin
                    w_nextState = ST_CONV;
                end
            end
            ST_CONV: w_nextState = ST_HDR;
            ST_HDR: begin
                if (w_fire) begin
                    w_nextState = ST_DIG;
                    w_nextIdx   = IDXW'(DIGITS - 1);
                    w_nextSeen  = 1'b0;
                end
            end
            ST_DIG: begin
                if (w_fire) begin
                    w_nextSeen = r_seenNz | (w_curDigit != 4'd0);
                    if (r_digIdx == '0) begin
                        w_nextState = ST_CR;
                    end else begin
                        w_nextIdx = r_digIdx - IDXW'(1);
                    end
                end
            end
            ST_CR: if (w_fire) w_nextState = ST_LF;
            ST_LF: if (w_fire) w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    assign w_nextDigit = r_bcdReg[w_nextIdx*4 +: 4];

    // The byte for the coming cycle is decoded from the next state so tx_data leaves a register.
    always_comb begin
        w_nextData = 8'h00;
        case (w_nextState)
            ST_HDR: w_nextData = (r_src == SRC_CAL) ? HDR_CAL : HDR_MEAS;
            ST_DIG: begin
`ifdef LZ_SUPPRESS_EN
                if ((w_nextDigit == 4'd0) && !w_nextSeen && (w_nextIdx != '0)) begin
                    w_nextData = SPACE;
                end else begin
                    w_nextData = ZERO + {4'h0, w_nextDigit};
                end
`else
                w_nextData = ZERO + {4'h0, w_nextDigit};
`endif
            end
            ST_CR:   w_nextData = CR;
            ST_LF:   w_nextData = LF;
            default: w_nextData = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Operands are captured only at grant so later input changes cannot disturb a frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lastGrant <= SRC_CAL;
            r_src       <= SRC_MEAS;
            r_opReg     <= '0;
            r_bcdReg    <= '0;
            r_digIdx    <= '0;
            r_seenNz    <= 1'b0;
            r_measAck   <= 1'b0;
            r_calAck    <= 1'b0;
            r_txValid   <= 1'b0;
            r_txData    <= 8'h00;
        end else begin
            r_measAck <= w_grant && (w_grantSrc == SRC_MEAS);
            r_calAck  <= w_grant && (w_grantSrc == SRC_CAL);
            if (w_grant) begin
                r_lastGrant <= w_grantSrc;
                r_src       <= w_grantSrc;
                r_opReg     <= (w_grantSrc == SRC_CAL) ? bus.cal_val : bus.meas_val;
            end
            if (r_state == ST_CONV) begin
                r_bcdReg <= w_conv;
            end
            r_digIdx  <= w_nextIdx;
            r_seenNz  <= w_nextSeen;
            r_txValid <= (w_nextState == ST_HDR) || (w_nextState == ST_DIG) ||
                         (w_nextState == ST_CR)  || (w_nextState == ST_LF);
            r_txData  <= w_nextData;
        end
    end

    assign bus.meas_ack = r_measAck;
    assign bus.cal_ack  = r_calAck;
    assign bus.tx_valid = r_txValid;
    assign bus.tx_data  = r_txData;
    assign bus.busy     = (r_state != ST_IDLE);

endmodule
